// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline types and constants used by the fetch controller
// and its hold watchdog.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_pipe_ctrl_if.sv
// Fetch-stage bus: hazard stall requests, EX branch resolution and
// instruction memory on one side, PC and IF/ID register on the other.
interface fetch_pipe_ctrl_if;

  logic        hold_PC;
  logic        hold_IFID;
  logic [31:0] IM_Instruction;
  logic        branch_resolved;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] PC;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        IDEX_Bubble;
  logic        hold_timeout;

  modport master (
    output hold_PC, hold_IFID, IM_Instruction,
           branch_resolved, branch_taken, branch_target,
    input  PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           IDEX_Bubble, hold_timeout
  );

  modport slave (
    input  hold_PC, hold_IFID, IM_Instruction,
           branch_resolved, branch_taken, branch_target,
    output PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           IDEX_Bubble, hold_timeout
  );

endinterface

// File: rtl/hold_watchdog.sv
// Counts consecutive honored-hold cycles and forces one fetch advance when
// the count reaches MAX_HOLD, so stuck stall requests cannot deadlock fetch.
module hold_watchdog
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  fetch_state_t state,
  input  fetch_state_t state_n,
  output logic         force_adv,
  output logic         hold_timeout
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_HOLD);

  logic [7:0] hold_cnt;

  assign force_adv = (state == HOLD) && (hold_cnt == MAX_CNT);

  // The count restarts whenever the FSM leaves HOLD, including on a redirect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_cnt     <= 8'd0;
      hold_timeout <= 1'b0;
    end else begin
      hold_cnt     <= (state_n == HOLD) ? hold_cnt + 8'd1 : 8'd0;
      hold_timeout <= force_adv;
    end
  end

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch pipeline controller: owns PC and IF/ID, applies stalls, bubbles and
// branch redirects. Optional macro FETCH_PERF_COUNTERS_EN adds stall/flush counters.
//
// state    | meaning
// RUN      | normal fetch, PC advances every cycle unless held
// HOLD     | hazard stall in progress, watchdog counting
// REDIRECT | first fetch from a branch target, holds ignored
module fetch_pipe_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned MAX_HOLD  = 8,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  fetch_pipe_ctrl_if.slave  bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  fetch_state_t state, state_n;

  logic [31:0] pc, pc_n;
  logic [31:0] ifid_instr, instr_n;
  logic [31:0] ifid_pcp4, pcp4_n;
  logic        ifid_valid, valid_n;

  logic redirect_now;
  logic force_adv;
  logic suppress;
  logic hold_eff_ifid;
  logic hold_eff_pc;
  logic timeout_pulse;

  assign redirect_now  = bus.branch_resolved & bus.branch_taken;
  assign suppress      = redirect_now | (state == REDIRECT) | force_adv;
  assign hold_eff_ifid = bus.hold_IFID & ~suppress;
  // Holding IF/ID alone must also freeze PC or the fetched word is lost.
  assign hold_eff_pc   = (bus.hold_PC | bus.hold_IFID) & ~suppress;

  hold_watchdog #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_watchdog (
    .Clk          (Clk),
    .Reset        (Reset),
    .state        (state),
    .state_n      (state_n),
    .force_adv    (force_adv),
    .hold_timeout (timeout_pulse)
  );

  // REDIRECT and the watchdog cycle fall into the advance branch via suppress.
  always_comb begin
    state_n = RUN;
    pc_n    = next_pc(pc);
    instr_n = bus.IM_Instruction;
    pcp4_n  = next_pc(pc);
    valid_n = 1'b1;
    if (redirect_now) begin
      state_n = REDIRECT;
      pc_n    = bus.branch_target;
      instr_n = NOP_INSTR;
      pcp4_n  = 32'd0;
      valid_n = 1'b0;
    end else if (hold_eff_pc) begin
      state_n = HOLD;
      pc_n    = pc;
      if (hold_eff_ifid) begin
        instr_n = ifid_instr;
        pcp4_n  = ifid_pcp4;
        valid_n = ifid_valid;
      end else begin
        instr_n = NOP_INSTR;
        pcp4_n  = 32'd0;
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pcp4  <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ifid_instr <= instr_n;
      ifid_pcp4  <= pcp4_n;
      ifid_valid <= valid_n;
    end
  end

  assign bus.PC               = pc;
  assign bus.IFID_Instruction = ifid_instr;
  assign bus.IFID_PCPlus4     = ifid_pcp4;
  assign bus.IFID_Valid       = ifid_valid;
  assign bus.hold_timeout     = timeout_pulse;
  assign bus.IDEX_Bubble      = ~Reset & (hold_eff_ifid | ~ifid_valid);

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 16'd0;
    end else begin
      if (hold_eff_pc && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_now && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Self-checking bench for fetch_pipe_ctrl: per-scenario stimulus tables with
// expected bubble/register values queued at drive time and popped after the edge.
module tb_fetch_pipe_ctrl;

  localparam logic [31:0] IM_KEY = 32'h5A5A_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        timeout;
  } regs_t;

  typedef struct {
    logic        rst, hp, hi, br, bt;
    logic [31:0] tgt;
    logic        bubble;
    regs_t       regs;
  } stim_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   passed = 0;
  stim_t q[$];

  fetch_pipe_ctrl_if bus ();

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  fetch_pipe_ctrl #(
    .RESET_PC  (32'h0000_0100),
    .MAX_HOLD  (8),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .bus          (bus)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Combinational instruction memory: word content derived from its address.
  assign bus.IM_Instruction = bus.PC ^ IM_KEY;

  function automatic regs_t ex(input logic [31:0] pc, input logic [31:0] iaddr,
                               input logic valid, input logic to);
    regs_t r;
    r.pc      = pc;
    r.instr   = valid ? (iaddr ^ IM_KEY) : 32'h0;
    r.pcp4    = valid ? (iaddr + 32'd4) : 32'h0;
    r.valid   = valid;
    r.timeout = to;
    return r;
  endfunction

  function automatic stim_t st(input logic rst, input logic hp, input logic hi,
                               input logic br, input logic bt, input logic [31:0] tgt,
                               input logic bubble, input regs_t regs);
    stim_t s;
    s.rst = rst; s.hp = hp; s.hi = hi; s.br = br; s.bt = bt; s.tgt = tgt;
    s.bubble = bubble; s.regs = regs;
    return s;
  endfunction

  function automatic regs_t observe();
    regs_t r;
    r.pc      = bus.PC;
    r.instr   = bus.IFID_Instruction;
    r.pcp4    = bus.IFID_PCPlus4;
    r.valid   = bus.IFID_Valid;
    r.timeout = bus.hold_timeout;
    return r;
  endfunction

  task automatic drive(input stim_t s);
    Reset               = s.rst;
    bus.hold_PC         = s.hp;
    bus.hold_IFID       = s.hi;
    bus.branch_resolved = s.br;
    bus.branch_taken    = s.bt;
    bus.branch_target   = s.tgt;
  endtask

  task automatic test_reset();
    stim_t s[$];
    stim_t e;
    regs_t got;
    s.push_back(st(1, 0, 0, 0, 0, 0, 0, ex(32'h100, 0, 0, 0)));
    s.push_back(st(1, 1, 1, 1, 1, 32'h40, 0, ex(32'h100, 0, 0, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL reset_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL reset_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  task automatic test_sequential();
    stim_t s[$];
    stim_t e;
    regs_t got;
    s.push_back(st(0, 0, 0, 0, 0, 0, 1, ex(32'h104, 32'h100, 1, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, ex(32'h108, 32'h104, 1, 0)));
    // Not-taken resolution must not disturb sequential fetch.
    s.push_back(st(0, 0, 0, 1, 0, 32'h999, 0, ex(32'h10C, 32'h108, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL seq_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL seq_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  task automatic test_hold_both();
    stim_t s[$];
    stim_t e;
    regs_t got;
    s.push_back(st(0, 0, 0, 1, 1, 32'h1C, 0, ex(32'h1C, 0, 0, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1, ex(32'h20, 32'h1C, 1, 0)));
    s.push_back(st(0, 1, 1, 0, 0, 0, 1, ex(32'h20, 32'h1C, 1, 0)));
    s.push_back(st(0, 1, 1, 0, 0, 0, 1, ex(32'h20, 32'h1C, 1, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, ex(32'h24, 32'h20, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL hold_both_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL hold_both_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  task automatic test_hold_pc_only();
    stim_t s[$];
    stim_t e;
    regs_t got;
    s.push_back(st(0, 1, 0, 0, 0, 0, 0, ex(32'h24, 0, 0, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1, ex(32'h28, 32'h24, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL hold_pc_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL hold_pc_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  task automatic test_redirect_with_hold();
    stim_t s[$];
    stim_t e;
    regs_t got;
    s.push_back(st(0, 0, 1, 1, 1, 32'h400, 0, ex(32'h400, 0, 0, 0)));
    // Hold during REDIRECT refers to the flushed slot and is ignored.
    s.push_back(st(0, 0, 1, 0, 0, 0, 1, ex(32'h404, 32'h400, 1, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, ex(32'h408, 32'h404, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL redirect_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL redirect_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  task automatic test_watchdog();
    stim_t s[$];
    stim_t e;
    regs_t got;
    for (int k = 0; k < 8; k++) s.push_back(st(0, 1, 1, 0, 0, 0, 1, ex(32'h408, 32'h404, 1, 0)));
    s.push_back(st(0, 1, 1, 0, 0, 0, 0, ex(32'h40C, 32'h408, 1, 1)));
    for (int k = 0; k < 8; k++) s.push_back(st(0, 1, 1, 0, 0, 0, 1, ex(32'h40C, 32'h408, 1, 0)));
    // Redirect on the watchdog cycle: redirect wins, timeout still pulses.
    s.push_back(st(0, 1, 1, 1, 1, 32'h800, 0, ex(32'h800, 0, 0, 1)));
    s.push_back(st(0, 1, 1, 0, 0, 0, 1, ex(32'h804, 32'h800, 1, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, ex(32'h808, 32'h804, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL watchdog_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL watchdog_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    stim_t s[$];
    stim_t e;
    regs_t got;
    s.push_back(st(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, ex(32'hFFFF_FFF8, 0, 0, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1, ex(32'hFFFF_FFFC, 32'hFFFF_FFF8, 1, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0, ex(32'h0000_0000, 32'hFFFF_FFFC, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL wrap_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL wrap_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  task automatic test_reset_in_hold();
    stim_t s[$];
    stim_t e;
    regs_t got;
    s.push_back(st(0, 1, 1, 0, 0, 0, 1, ex(32'h0, 32'hFFFF_FFFC, 1, 0)));
    s.push_back(st(1, 1, 1, 0, 0, 0, 0, ex(32'h100, 0, 0, 0)));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1, ex(32'h104, 32'h100, 1, 0)));
    foreach (s[i]) begin
      drive(s[i]); q.push_back(s[i]); #1;
      checks++;
      if (bus.IDEX_Bubble !== q[0].bubble)
        $display("FAIL reset_hold_bubble step %0d: got %b want %b", i, bus.IDEX_Bubble, q[0].bubble);
      else passed++;
      @(posedge Clk); #1;
      e = q.pop_front(); got = observe(); checks++;
      if (got !== e.regs)
        $display("FAIL reset_hold_regs step %0d: got pc=%h ins=%h p4=%h v=%b to=%b want pc=%h ins=%h p4=%h v=%b to=%b",
                 i, got.pc, got.instr, got.pcp4, got.valid, got.timeout,
                 e.regs.pc, e.regs.instr, e.regs.pcp4, e.regs.valid, e.regs.timeout);
      else passed++;
    end
  endtask

  initial begin
    Reset               = 1'b1;
    bus.hold_PC         = 1'b0;
    bus.hold_IFID       = 1'b0;
    bus.branch_resolved = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.branch_target   = 32'h0;
    @(posedge Clk); #1;
    test_reset();
    test_sequential();
    test_hold_both();
    test_hold_pc_only();
    test_redirect_with_hold();
    test_watchdog();
    test_wrap();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
